fifo_stream_reader: RTL and testbench

- Read-side engine for the team's synchronous FIFO (wr_en/wr_data/full, rd_en/rd_data/empty, 1-cycle registered read latency).
- Drains the FIFO and presents the words as a valid/ready stream.
- Uses a 2-entry prefetch buffer to sustain 1 word/cycle despite the FIFO read latency.
- Sits between the FIFO and any downstream stream consumer; supports a local flush and counts delivered words.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/stream_buf2.sv | 62 ++++++
 rtl/fifo_stream_reader.sv | 75 +++++++
 tb/tb_fifo_stream_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and word type for the synchronous FIFO, its stream reader
// and the benches that drive them.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH     = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered buffer feeding the stream output.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, push_data  append a word at the tail
//   pop              drop the head word
//   clear            discard all entries (wins over push/pop)
//   head             oldest word (slot 0)
//   cnt              number of valid entries, 0..2
// Slot 0 always holds the head, so head is a plain register output and stays
// stable while nothing is popped.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);

  logic [W-1:0] e0, e1;

  assign head = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves and the new word lands behind whatever remains.
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: drains it into a valid/ready
// stream at up to one word per cycle, hiding the FIFO's one-cycle read latency
// with a two-entry prefetch buffer.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   fifo_rd_en     read request to the FIFO
//   fifo_rd_data   FIFO data, valid the cycle after an accepted read
//   fifo_empty     FIFO empty flag
//   m_valid/m_data/m_ready   output stream
//   flush          drop buffered and in-flight words this cycle
//   word_cnt       stream transfers since reset (wraps)
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [1:0] buf_cnt;
  logic       inflight;
  logic       pop;
  logic       capture;
  logic [2:0] occ;

  assign m_valid = (buf_cnt != 2'd0) && !flush;
  assign pop     = m_valid && m_ready;

  // Slots committed after this edge: held words plus the one arriving, minus
  // the one leaving. Never negative since pop implies buf_cnt >= 1.
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};

  // rst_n gates the request so it drops the instant reset asserts, even if
  // the FIFO still reports data.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush && (occ < 3'd2);

  assign capture = inflight && !flush;

  stream_buf2 #(.W(DATA_WIDTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (capture),
    .push_data(fifo_rd_data),
    .pop      (pop),
    .clear    (flush),
    .head     (m_data),
    .cnt      (buf_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

  // The issue rule keeps buf_cnt + inflight <= 2, so a capture never meets a
  // full buffer unless the head leaves on the same edge.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && buf_cnt == 2'd2 && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model supplies the words,
// and a queue of "words pulled but not yet delivered" is the scoreboard.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  word_t         fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  word_t         m_data;
  logic          m_ready;
  logic          flush;
  logic [CW-1:0] word_cnt;

  logic  wr_en;
  word_t wr_data;

  word_t fq[$];   // FIFO contents
  word_t rq[$];   // words read from the FIFO, not yet delivered
  word_t tmp;

  int errors = 0, checks = 0;
  int cyc = 0, n_pop = 0;
  int phase_pops, phase_rd, acc_wr, t_rd, t_v, t_last;
  bit seen_rd, seen_v;
  word_t first_pop;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DEF_DATA_WIDTH), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .flush       (flush),
    .word_cnt    (word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered read data, read served before the same-edge write.
  // A flush drops everything already pulled out of the FIFO.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      rq.delete();
      n_pop = 0;
      fifo_empty   <= 1'b1;
      fifo_rd_data <= '0;
    end else begin
      cyc++;
      if (flush) rq.delete();
      if (fifo_rd_en && fq.size() > 0) begin
        tmp = fq.pop_front();
        fifo_rd_data <= tmp;
        rq.push_back(tmp);
      end
      if (wr_en && fq.size() < FIFO_DEPTH) begin
        fq.push_back(wr_data);
        acc_wr++;
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
      chk("word_cnt_track", {16'd0, word_cnt}, {16'd0, n_pop[CW-1:0]});
      if (fifo_rd_en) begin
        phase_rd++;
        if (!seen_rd) begin seen_rd = 1'b1; t_rd = cyc; end
      end
      if (m_valid && !seen_v) begin seen_v = 1'b1; t_v = cyc; end
      if (m_valid && m_ready) begin
        chk("pop_has_word", {31'd0, rq.size() > 0}, 32'd1);
        if (rq.size() > 0) begin
          chk("pop_data", {24'd0, m_data}, {24'd0, rq[0]});
          void'(rq.pop_front());
        end
        if (phase_pops == 0) first_pop = m_data;
        n_pop++;
        phase_pops++;
        t_last = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic arm();
    phase_pops = 0; phase_rd = 0; acc_wr = 0;
    seen_rd = 1'b0; seen_v = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int k = 0;
    while (phase_pops < target && k < budget) begin tick(); k++; end
    chk(tag, {31'd0, phase_pops >= target}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w0;
    int k;
    wr_en = 0; wr_data = '0; m_ready = 0; flush = 0;
    arm();
    tick(2);
    chk("reset_valid",  {31'd0, m_valid}, 32'd0);
    chk("reset_rd_en",  {31'd0, fifo_rd_en}, 32'd0);
    chk("reset_cnt",    {16'd0, word_cnt}, 32'd0);
    chk("reset_data",   {24'd0, m_data}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: five words 0..4, ready held high
    arm(); m_ready = 1;
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = word_t'(i); tick(); end
    wr_en = 0;
    wait_pops(5, 40, "t1_done");
    tick(3);
    chk("t1_latency",  t_v - t_rd, 32'd2);
    chk("t1_word_cnt", {16'd0, word_cnt}, 32'd5);
    chk("t1_rd_idle",  {31'd0, fifo_rd_en}, 32'd0);
    chk("t1_v_idle",   {31'd0, m_valid}, 32'd0);

    // 2: sixteen random words back-to-back, no bubbles
    arm();
    for (int i = 0; i < 16; i++) begin wr_en = 1; wr_data = word_t'($urandom); tick(); end
    wr_en = 0;
    wait_pops(16, 60, "t2_done");
    chk("t2_no_bubbles", t_last - t_v + 1, 32'd16);
    chk("t2_word_cnt",   {16'd0, word_cnt}, 32'd21);

    // 3: backpressure holds two words, head stable
    arm(); m_ready = 0;
    w0 = '0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = word_t'($urandom);
      if (i == 0) w0 = wr_data;
      tick();
    end
    wr_en = 0;
    tick(4);
    chk("t3_head_early", {24'd0, m_data}, {24'd0, w0});
    tick(16);
    chk("t3_rd_pulses", phase_rd, 32'd2);
    chk("t3_valid",     {31'd0, m_valid}, 32'd1);
    chk("t3_head_late", {24'd0, m_data}, {24'd0, w0});
    m_ready = 1;
    wait_pops(16, 60, "t3_done");
    chk("t3_word_cnt", {16'd0, word_cnt}, 32'd37);

    // 4: flush with one word buffered and one in flight
    arm(); m_ready = 0;
    for (int i = 0; i < 8; i++) begin wr_en = 1; wr_data = word_t'(8'h40 + i); tick(); end
    wr_en = 0;
    tick(6);
    chk("t4_pre_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1;
    tick();            // 0x40 leaves, 0x42 requested
    flush = 1;         // 0x41 buffered, 0x42 arriving
    #1;
    chk("t4_flush_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_flush_rd",    {31'd0, fifo_rd_en}, 32'd0);
    chk("t4_flush_cnt",   {16'd0, word_cnt}, 32'd38);
    tick();
    flush = 0;
    #1;
    chk("t4_resume_rd", {31'd0, fifo_rd_en}, 32'd1);
    arm();
    wait_pops(5, 40, "t4_done");
    chk("t4_next_word", {24'd0, first_pop}, 32'h43);
    tick();
    chk("t4_word_cnt", {16'd0, word_cnt}, 32'd43);

    // 5: asynchronous reset mid-stream
    arm(); m_ready = 0;
    for (int i = 0; i < 3; i++) begin wr_en = 1; wr_data = word_t'($urandom); tick(); end
    wr_en = 0;
    tick(5);
    chk("t5_pre_valid", {31'd0, m_valid}, 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t5_rst_cnt",   {16'd0, word_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1;
    arm();
    tick(8);
    chk("t5_no_valid", {31'd0, seen_v}, 32'd0);
    chk("t5_cnt_zero", {16'd0, word_cnt}, 32'd0);

    // 6: random traffic, then drain
    arm();
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_data = word_t'($urandom);
      m_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    wr_en = 0; m_ready = 1;
    k = 0;
    while ((fq.size() > 0 || rq.size() > 0) && k < 100) begin tick(); k++; end
    tick(2);
    chk("t6_drained",       fq.size() + rq.size(), 32'd0);
    chk("t6_all_delivered", phase_pops, acc_wr);
    chk("t6_word_cnt",      {16'd0, word_cnt}, phase_pops);
    chk("t6_idle_valid",    {31'd0, m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
